spill_fifo_flushable: RTL and testbench

- Generalised successor to the single-stage spill register used on AXI channel paths (AW/W/AR/R/B slices).
- Depth-parametrised elastic buffer with a synchronous flush and an occupancy output.
- Keeps the spill-register timing property: no combinational path from ready_i to ready_o, and none from valid_i/data_i to valid_o/data_o, except in bypass mode.
- Instantiated per channel in axi_to_mem and related bridges wherever cut timing plus more than one beat of slack is needed.

---
 rtl/spill_fifo_pkg.sv | 26 ++
 rtl/spill_fifo_ctrl.sv | 76 +++++++
 rtl/spill_fifo_flushable.sv | 94 +++++++++
 tb/tb_spill_fifo_flushable.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spill_fifo_pkg.sv
// rtl/spill_fifo_pkg.sv - shared sizing limits and pointer helpers for spill/elastic buffers
package spill_fifo_pkg;

    localparam int MaxDepth    = 16;
    localparam int MaxPtrWidth = $clog2(MaxDepth);

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width for a buffer of the given depth; a depth of 1 still gets one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Advance a circular pointer, wrapping at depth-1 by compare so odd depths work.
    function automatic logic [MaxPtrWidth-1:0] ptr_inc(input logic [MaxPtrWidth-1:0] ptr,
                                                        input int depth);
        if (int'(ptr) == depth - 1) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/spill_fifo_ctrl.sv
// rtl/spill_fifo_ctrl.sv - pointer, occupancy, flush and handshake control for the spill FIFO
module spill_fifo_ctrl
    import spill_fifo_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          push,
    output logic [ptr_width(Depth)-1:0]   wr_ptr,
    output logic [ptr_width(Depth)-1:0]   rd_ptr,
    output logic [cnt_width(Depth)-1:0]   count
);

    localparam int PtrWidth = ptr_width(Depth);
    localparam int CntWidth = cnt_width(Depth);
    localparam logic [CntWidth-1:0] FullCount = CntWidth'(Depth);

    logic [CntWidth-1:0] count_d;
    logic [PtrWidth-1:0] wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_d;
    logic                pop;

    function automatic logic [PtrWidth-1:0] step_ptr(input logic [PtrWidth-1:0] p);
        return PtrWidth'(ptr_inc(MaxPtrWidth'(p), Depth));
    endfunction

    // Flags come only from the registered count, so neither handshake input reaches them.
    assign in_ready  = (count != FullCount) && !flush;
    assign out_valid = (count != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next pointer/count state; flush wins over any handshake and empties the buffer.
    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = step_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr_d = step_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_d = count + 1'b1;
                2'b01:   count_d = count - 1'b1;
                default: count_d = count;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            count  <= count_d;
        end
    end

endmodule

// File: rtl/spill_fifo_flushable.sv
// rtl/spill_fifo_flushable.sv - depth-parametrised flushable spill FIFO (optional SPILL_FIFO_STALL_CNT_EN stall counter)
module spill_fifo_flushable
    import spill_fifo_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Depth     = 2,
    parameter bit Bypass    = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DataWidth-1:0]         data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DataWidth-1:0]         data_o,
    output logic [cnt_width(Depth)-1:0]  usage_o
`ifdef SPILL_FIFO_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt_o
`endif
);

    if (Depth < 1 || Depth > MaxDepth) begin : g_depth_check
        $error("spill_fifo_flushable: Depth must lie within 1..16");
    end

    if (Bypass) begin : g_bypass
        logic bypass_unused;

        assign valid_o       = valid_i;
        assign ready_o       = ready_i;
        assign data_o        = data_i;
        assign usage_o       = '0;
        assign bypass_unused = ^{clk_i, rst_ni, flush_i};
    end else begin : g_fifo
        localparam int PtrWidth = ptr_width(Depth);
        localparam int Slots    = 2 ** PtrWidth;

        logic [DataWidth-1:0] mem [Slots];
        logic                 push;
        logic [PtrWidth-1:0]  wr_ptr;
        logic [PtrWidth-1:0]  rd_ptr;

        spill_fifo_ctrl #(
            .Depth (Depth)
        ) u_ctrl (
            .clk       (clk_i),
            .rst_n     (rst_ni),
            .flush     (flush_i),
            .in_valid  (valid_i),
            .in_ready  (ready_o),
            .out_valid (valid_o),
            .out_ready (ready_i),
            .push      (push),
            .wr_ptr    (wr_ptr),
            .rd_ptr    (rd_ptr),
            .count     (usage_o)
        );

        // Storage write; entries are cleared only by reset so data_o reads zero out of reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < Slots; i++) begin
                    mem[i] <= '0;
                end
            end else if (push) begin
                mem[wr_ptr] <= data_i;
            end
        end

        assign data_o = mem[rd_ptr];
    end

`ifdef SPILL_FIFO_STALL_CNT_EN
    logic stall;

    // In bypass valid_o is valid_i, so this covers both modes.
    assign stall = valid_o && !ready_i;

    // Saturating count of stalled cycles, cleared by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            stall_cnt_o <= '0;
        end else if (stall && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spill_fifo_flushable.sv
// tb/tb_spill_fifo_flushable.sv - scoreboard bench for spill_fifo_flushable (Depth 3/2/1 and bypass)
module tb_spill_fifo_flushable;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Depth=3 instance
    logic         f3 = 1'b0, vi3 = 1'b0, ri3 = 1'b0;
    logic [W-1:0] di3 = '0;
    logic         vo3, ro3;
    logic [W-1:0] do3;
    logic [1:0]   u3;
    // Depth=2 instance
    logic         f2 = 1'b0, vi2 = 1'b0, ri2 = 1'b0;
    logic [W-1:0] di2 = '0;
    logic         vo2, ro2;
    logic [W-1:0] do2;
    logic [1:0]   u2;
    // Depth=1 instance
    logic         f1 = 1'b0, vi1 = 1'b0, ri1 = 1'b0;
    logic [W-1:0] di1 = '0;
    logic         vo1, ro1;
    logic [W-1:0] do1;
    logic [0:0]   u1;
    // Bypass instance
    logic         fb = 1'b0, vib = 1'b0, rib = 1'b0;
    logic [W-1:0] dib = '0;
    logic         vob, rob;
    logic [W-1:0] dob;
    logic [1:0]   ub;
`ifdef SPILL_FIFO_STALL_CNT_EN
    logic [15:0]  sc3, sc2, sc1, scb;
`endif

    spill_fifo_flushable #(.DataWidth(W), .Depth(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .valid_i(vi3), .ready_o(ro3), .data_i(di3),
        .valid_o(vo3), .ready_i(ri3), .data_o(do3), .usage_o(u3)
`ifdef SPILL_FIFO_STALL_CNT_EN
        , .stall_cnt_o(sc3)
`endif
    );
    spill_fifo_flushable #(.DataWidth(W), .Depth(2)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f2), .valid_i(vi2), .ready_o(ro2), .data_i(di2),
        .valid_o(vo2), .ready_i(ri2), .data_o(do2), .usage_o(u2)
`ifdef SPILL_FIFO_STALL_CNT_EN
        , .stall_cnt_o(sc2)
`endif
    );
    spill_fifo_flushable #(.DataWidth(W), .Depth(1)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .valid_i(vi1), .ready_o(ro1), .data_i(di1),
        .valid_o(vo1), .ready_i(ri1), .data_o(do1), .usage_o(u1)
`ifdef SPILL_FIFO_STALL_CNT_EN
        , .stall_cnt_o(sc1)
`endif
    );
    spill_fifo_flushable #(.DataWidth(W), .Depth(2), .Bypass(1'b1)) u_byp (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fb), .valid_i(vib), .ready_o(rob), .data_i(dib),
        .valid_o(vob), .ready_i(rib), .data_o(dob), .usage_o(ub)
`ifdef SPILL_FIFO_STALL_CNT_EN
        , .stall_cnt_o(scb)
`endif
    );

    logic [W-1:0] q3[$], q2[$], q1[$];
    int           beats3 = 0, beats2 = 0, beats1 = 0;
    bit           seen55 = 1'b0;
    logic         pv3 = 1'b0;
    logic [W-1:0] pd3 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Depth=3 monitor: output beats against the scoreboard, plus hold-under-backpressure.
    always @(negedge clk) begin
        if (rst_n && pv3 && !f3) begin
            check("d3_hold_valid", {31'd0, vo3}, 32'd1);
            check("d3_hold_data", {24'd0, do3}, {24'd0, pd3});
        end
        if (vo3 && ri3) begin
            beats3++;
            if (do3 == 8'h55) seen55 = 1'b1;
            if (q3.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d3_beat: got 0x%0h, expected no beat", do3);
            end else begin
                check("d3_beat", {24'd0, do3}, {24'd0, q3.pop_front()});
            end
        end
        pv3 = vo3 && !ri3;
        pd3 = do3;
    end

    // Depth=2 monitor.
    always @(negedge clk) begin
        if (vo2 && ri2) begin
            beats2++;
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d2_beat: got 0x%0h, expected no beat", do2);
            end else begin
                check("d2_beat", {24'd0, do2}, {24'd0, q2.pop_front()});
            end
        end
    end

    // Depth=1 monitor.
    always @(negedge clk) begin
        if (vo1 && ri1) begin
            beats1++;
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d1_beat: got 0x%0h, expected no beat", do1);
            end else begin
                check("d1_beat", {24'd0, do1}, {24'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit accepted;
        int bub2;
        int first2;

        // Reset / empty
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid3", {31'd0, vo3}, 32'd0);
        check("rst_ready3", {31'd0, ro3}, 32'd1);
        check("rst_usage3", {30'd0, u3}, 32'd0);
        check("rst_data3", {24'd0, do3}, 32'd0);
        check("rst_ready1", {31'd0, ro1}, 32'd1);
        check("rst_usage1", {31'd0, u1}, 32'd0);

        // Fill to full with ready_i low, hold a fourth beat, then drain in order
        step();
        q3.push_back(8'hA1); q3.push_back(8'hA2); q3.push_back(8'hA3); q3.push_back(8'hA4);
        vi3 = 1'b1; ri3 = 1'b0; di3 = 8'hA1;
        step(); di3 = 8'hA2;
        step(); di3 = 8'hA3;
        step(); di3 = 8'hA4;
        @(negedge clk);
        check("full_usage", {30'd0, u3}, 32'd3);
        check("full_ready", {31'd0, ro3}, 32'd0);
        check("full_valid", {31'd0, vo3}, 32'd1);
        check("full_head", {24'd0, do3}, 32'hA1);
        step();
        ri3 = 1'b1;
        #1 check("comb_ready_full", {31'd0, ro3}, 32'd0);
        ri3 = 1'b0; vi3 = 1'b0; di3 = 8'hEE;
        #1 check("comb_valid", {31'd0, vo3}, 32'd1);
        check("comb_data", {24'd0, do3}, 32'hA1);
        vi3 = 1'b1; di3 = 8'hA4;
        @(negedge clk);
        check("full_hold_usage", {30'd0, u3}, 32'd3);
        step(); ri3 = 1'b1;
        step();
        @(negedge clk);
        check("ready_rises", {31'd0, ro3}, 32'd1);
        check("after_pop_usage", {30'd0, u3}, 32'd2);
        step(); vi3 = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("drain_usage", {30'd0, u3}, 32'd0);
        check("drain_q3", q3.size(), 32'd0);

        // Flush with two entries and a 0x55 beat offered during the flush cycle
        step(); vi3 = 1'b1; ri3 = 1'b0; di3 = 8'hB1;
        step(); di3 = 8'hB2;
        step(); f3 = 1'b1; di3 = 8'h55;
        @(negedge clk);
        check("pre_flush_usage", {30'd0, u3}, 32'd2);
        check("flush_valid", {31'd0, vo3}, 32'd0);
        check("flush_ready", {31'd0, ro3}, 32'd0);
        step(); f3 = 1'b0; vi3 = 1'b0;
        @(negedge clk);
        check("post_flush_usage", {30'd0, u3}, 32'd0);
        check("post_flush_valid", {31'd0, vo3}, 32'd0);
        step(); q3.push_back(8'hC1); vi3 = 1'b1; ri3 = 1'b1; di3 = 8'hC1;
        step(); vi3 = 1'b0;
        repeat (3) step();
        check("no_55", {31'd0, seen55}, 32'd0);
        check("flush_q3", q3.size(), 32'd0);

        // Random backpressure: ordering and hold-stability
        for (int i = 0; i < 16; i++) q3.push_back(8'(8'h10 + i));
        for (int i = 0; i < 16; i++) begin
            vi3 = 1'b1;
            di3 = 8'(8'h10 + i);
            accepted = 1'b0;
            for (int k = 0; k < 50 && !accepted; k++) begin
                @(negedge clk);
                accepted = ro3;
                step();
                ri3 = 1'($urandom_range(0, 1));
            end
            if (!accepted) begin
                tests++;
                fails++;
                $display("FAIL bp_accept: got timeout, expected beat %0d accepted", i);
            end
        end
        vi3 = 1'b0; ri3 = 1'b1;
        for (int k = 0; k < 40 && q3.size() != 0; k++) step();
        check("bp_drain", q3.size(), 32'd0);

        // Asynchronous reset with two beats in flight
        step(); vi3 = 1'b1; ri3 = 1'b0; di3 = 8'hD1;
        step(); di3 = 8'hD2;
        step(); vi3 = 1'b0;
        @(negedge clk);
        check("pre_rst_usage", {30'd0, u3}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, vo3}, 32'd0);
        check("arst_ready", {31'd0, ro3}, 32'd1);
        check("arst_usage", {30'd0, u3}, 32'd0);
        check("arst_data", {24'd0, do3}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step(); ri3 = 1'b1;
        repeat (3) step();
        check("arst_no_beats_usage", {30'd0, u3}, 32'd0);

        // Throughput: Depth=2 full rate, Depth=1 every other cycle
        step();
        vi2 = 1'b1; ri2 = 1'b1; vi1 = 1'b1; ri1 = 1'b1;
        beats2 = 0; beats1 = 0; bub2 = 0; first2 = -1;
        for (int i = 0; i < 100; i++) q2.push_back(8'(i));
        for (int i = 0; i < 100; i += 2) q1.push_back(8'(i));
        for (int i = 0; i < 100; i++) begin
            di2 = 8'(i);
            di1 = 8'(i);
            @(negedge clk);
            if (vo2 && first2 < 0) first2 = i;
            if (i >= 1 && !vo2) bub2++;
            step();
        end
        vi2 = 1'b0; vi1 = 1'b0;
        @(negedge clk);
        if (!vo2) bub2++;
        repeat (4) step();
        check("d2_first_beat", first2, 32'd1);
        check("d2_bubbles", bub2, 32'd0);
        check("d2_beats", beats2, 32'd100);
        check("d1_beats", beats1, 32'd50);
        check("d2_q", q2.size(), 32'd0);
        check("d1_q", q1.size(), 32'd0);

        // Bypass: pure wires, flush ignored
        step();
        vib = 1'b1; dib = 8'h3C; rib = 1'b0;
        #1;
        check("byp_valid", {31'd0, vob}, 32'd1);
        check("byp_data", {24'd0, dob}, 32'h3C);
        check("byp_ready0", {31'd0, rob}, 32'd0);
        check("byp_usage", {30'd0, ub}, 32'd0);
        dib = 8'hC3; rib = 1'b1;
        #1;
        check("byp_data2", {24'd0, dob}, 32'hC3);
        check("byp_ready1", {31'd0, rob}, 32'd1);
        fb = 1'b1; vib = 1'b0;
        #1;
        check("byp_flush_valid", {31'd0, vob}, 32'd0);
        check("byp_flush_ready", {31'd0, rob}, 32'd1);
        fb = 1'b0;

`ifdef SPILL_FIFO_STALL_CNT_EN
        // Stall counter: exact count, saturation, clear on flush
        step(); f3 = 1'b1; ri3 = 1'b0;
        step(); f3 = 1'b0;
        @(negedge clk);
        check("stall_clear", {16'd0, sc3}, 32'd0);
        step(); q3.push_back(8'h77); vi3 = 1'b1; di3 = 8'h77;
        step(); vi3 = 1'b0;
        repeat (5) step();
        check("stall_5", {16'd0, sc3}, 32'd5);
        repeat (70000) step();
        check("stall_sat", {16'd0, sc3}, 32'hFFFF);
        f3 = 1'b1; q3.delete();
        step(); f3 = 1'b0;
        @(negedge clk);
        check("stall_flush", {16'd0, sc3}, 32'd0);
`endif

        check("end_q3", q3.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
